// File: rtl/branch_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : branch_issue_sched
// Brief    : Shares one conditional-branch comparator among NUM_REQ branch
//            reservation-station entries. Round-robin arbitration feeds a
//            single registered resolve slot with consumer backpressure and
//            flush squash. Each resolved branch reports its taken flag,
//            next PC and mispredict flag.
// Options  : BRANCH_SCHED_STATS_EN adds the stat_resolved / stat_mispred
//            handshake counters. Without it those ports do not exist.
// Revision : 1.0 - initial release
// ============================================================================
module branch_issue_sched #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 6,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0][DATA_W-1:0] req_rs1,
   input  logic [NUM_REQ-1:0][DATA_W-1:0] req_rs2,
   input  logic [NUM_REQ-1:0][2:0]        req_func,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_pc,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_target,
   input  logic [NUM_REQ-1:0]             req_pred_taken,
   input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag,
   output logic [NUM_REQ-1:0]             grant,
   output logic                           resolve_valid,
   input  logic                           resolve_ready,
   output logic [TAG_W-1:0]               resolve_tag,
   output logic                           resolve_taken,
   output logic [ADDR_W-1:0]              resolve_next_pc,
   output logic                           resolve_mispredict
`ifdef BRANCH_SCHED_STATS_EN
   ,
   output logic [31:0]                    stat_resolved,
   output logic [31:0]                    stat_mispred
`endif
);

   // Round-robin pointer width; at least one bit even for the smallest build.
   localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [c_ptr_w-1:0] c_last_idx = c_ptr_w'(NUM_REQ - 1);
   localparam logic [ADDR_W-1:0]  c_pc_step  = ADDR_W'(4);

   // RISC-V funct3 branch encodings; 010 and 011 are unused and never taken.
   localparam logic [2:0] c_f3_beq  = 3'b000;
   localparam logic [2:0] c_f3_bne  = 3'b001;
   localparam logic [2:0] c_f3_blt  = 3'b100;
   localparam logic [2:0] c_f3_bge  = 3'b101;
   localparam logic [2:0] c_f3_bltu = 3'b110;
   localparam logic [2:0] c_f3_bgeu = 3'b111;

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } slot_state_t;

   slot_state_t                          r_state;
   logic        [c_ptr_w-1:0]            r_rr_ptr;
   logic        [TAG_W-1:0]              r_tag;
   logic                                 r_taken;
   logic        [ADDR_W-1:0]             r_next_pc;
   logic                                 r_mispredict;

   logic        [NUM_REQ-1:0][c_ptr_w-1:0] w_cand_idx;
   logic                                 w_req_any;
   logic        [c_ptr_w-1:0]            w_win_idx;
   logic                                 w_can_issue;
   logic        [NUM_REQ-1:0]            w_grant;
   logic                                 w_grant_any;

   logic        [DATA_W-1:0]             w_rs1;
   logic        [DATA_W-1:0]             w_rs2;
   logic        [2:0]                    w_func;
   logic        [ADDR_W-1:0]             w_pc;
   logic        [ADDR_W-1:0]             w_target;
   logic                                 w_pred_taken;
   logic        [TAG_W-1:0]              w_tag;
   logic                                 w_taken;
   logic        [ADDR_W-1:0]             w_next_pc;

   // Candidate order: offset i from the pointer, wrapped modulo NUM_REQ so
   // non-power-of-two requester counts still rotate correctly.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      localparam int c_off = gi;
      assign w_cand_idx[gi] = ((int'(r_rr_ptr) + c_off) >= NUM_REQ)
                              ? c_ptr_w'(int'(r_rr_ptr) + c_off - NUM_REQ)
                              : c_ptr_w'(int'(r_rr_ptr) + c_off);
   end

   // Pick the first valid requester at or after the round-robin pointer.
   always_comb begin
      w_req_any = 1'b0;
      w_win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_req_any && req_valid[w_cand_idx[i]]) begin
            w_req_any = 1'b1;
            w_win_idx = w_cand_idx[i];
         end
      end
   end

   // The slot can take a new branch only if it empties this cycle (or already
   // is empty) and no squash is in progress.
   assign w_can_issue = !flush && ((r_state == S_EMPTY) || resolve_ready);

   // One-hot grant to the arbitration winner when the slot can accept it.
   always_comb begin
      w_grant = '0;
      if (w_can_issue && w_req_any) begin
         w_grant[w_win_idx] = 1'b1;
      end
   end

   assign w_grant_any = |w_grant;
   assign grant       = w_grant;

   // Route the winner's operands to the shared comparator.
   assign w_rs1        = req_rs1[w_win_idx];
   assign w_rs2        = req_rs2[w_win_idx];
   assign w_func       = req_func[w_win_idx];
   assign w_pc         = req_pc[w_win_idx];
   assign w_target     = req_target[w_win_idx];
   assign w_pred_taken = req_pred_taken[w_win_idx];
   assign w_tag        = req_tag[w_win_idx];

   // Shared branch comparator; unknown encodings resolve as not taken.
   always_comb begin
      w_taken = 1'b0;
      case (w_func)
         c_f3_beq:  w_taken = (w_rs1 == w_rs2);
         c_f3_bne:  w_taken = (w_rs1 != w_rs2);
         c_f3_blt:  w_taken = ($signed(w_rs1) <  $signed(w_rs2));
         c_f3_bge:  w_taken = ($signed(w_rs1) >= $signed(w_rs2));
         c_f3_bltu: w_taken = (w_rs1 <  w_rs2);
         c_f3_bgeu: w_taken = (w_rs1 >= w_rs2);
         default:   w_taken = 1'b0;
      endcase
   end

   // Fall-through PC wraps naturally at the address width.
   assign w_next_pc = w_taken ? w_target : (w_pc + c_pc_step);

   // Slot FSM: capture the resolved branch on grant, release on handshake,
   // and drop everything on flush. Data holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_EMPTY;
         r_tag        <= '0;
         r_taken      <= 1'b0;
         r_next_pc    <= '0;
         r_mispredict <= 1'b0;
      end else if (flush) begin
         r_state <= S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_grant_any) begin
                  r_state      <= S_FULL;
                  r_tag        <= w_tag;
                  r_taken      <= w_taken;
                  r_next_pc    <= w_next_pc;
                  r_mispredict <= w_taken ^ w_pred_taken;
               end
            end
            S_FULL: begin
               if (w_grant_any) begin
                  // Back-to-back: the old branch leaves as the new one lands.
                  r_state      <= S_FULL;
                  r_tag        <= w_tag;
                  r_taken      <= w_taken;
                  r_next_pc    <= w_next_pc;
                  r_mispredict <= w_taken ^ w_pred_taken;
               end else if (resolve_ready) begin
                  r_state <= S_EMPTY;
               end
            end
            default: begin
               r_state <= S_EMPTY;
            end
         endcase
      end
   end

   // Advance the pointer past the winner; hold it when nothing is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
      end else if (w_grant_any) begin
         r_rr_ptr <= (w_win_idx == c_last_idx) ? '0 : (w_win_idx + 1'b1);
      end
   end

   assign resolve_valid      = (r_state == S_FULL);
   assign resolve_tag        = r_tag;
   assign resolve_taken      = r_taken;
   assign resolve_next_pc    = r_next_pc;
   assign resolve_mispredict = r_mispredict;

`ifdef BRANCH_SCHED_STATS_EN
   logic [31:0] r_stat_resolved;
   logic [31:0] r_stat_mispred;
   logic        w_handshake;

   assign w_handshake = resolve_valid && resolve_ready;

   // Count every slot handshake and the mispredicted subset; wraps at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_resolved <= '0;
         r_stat_mispred  <= '0;
      end else if (w_handshake) begin
         r_stat_resolved <= r_stat_resolved + 32'd1;
         if (r_mispredict) begin
            r_stat_mispred <= r_stat_mispred + 32'd1;
         end
      end
   end

   assign stat_resolved = r_stat_resolved;
   assign stat_mispred  = r_stat_mispred;
`else
   // Statistics counters are compiled out in this build.
`endif

endmodule
`default_nettype wire
